cumprod_stream: RTL and testbench
=================================

# cumprod_stream

Streaming, parametrised cumulative-product engine for the operator library. It accepts LANES independent fixed-point channels per beat over a valid/ready handshake and emits the running product of each lane along the reduction dimension. The running product restarts every seg_len beats, so one row/segment of the tensor is scanned per restart. It sits between the tensor-streaming front end and downstream operator modules.

## Interface
- DATA_W, 16, signed element width per lane.
- FRAC_W, 8, fractional bits (Q(DATA_W-FRAC_W).FRAC_W); 0 ≤ FRAC_W < DATA_W.
- LANES, 4, independent channels per beat.
- MAX_SEG, 1024, maximum segment length; counter width CNT_W = $clog2(MAX_SEG+1).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- seg_len  in  CNT_W  segment length; sampled at segment start; 0 is treated as 1, and values above MAX_SEG are treated as MAX_SEG.
- valid_in  in  1  input beat valid.
- ready_in  out  1  block can accept a beat.
- data_in  in  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- valid_out  out  1  output beat valid.
- ready_out  in  1  downstream accepts the beat.
- data_out  out  LANES*DATA_W  running product per lane, same packing as data_in.
- last_out  out  1  this beat closes a segment.
- sat_out  out  LANES  lane saturated at this beat or earlier in the current segment (sticky).

## Operation
- Accept condition: valid_in && ready_in.
- ready_in = !valid_out || ready_out.
- Per lane, on accept:
  - First beat of a segment (cnt==0): result = x. Unity is not multiplied, so no rounding is introduced.
  - Otherwise: p = acc*x as a 2*DATA_W signed product, then q = p >>> FRAC_W (arithmetic shift, truncation toward −inf).
  - result = sat(q) to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - acc ← result.
  - sat_sticky[i] ← (first ? 0 : sat_sticky[i]) | overflow.
- Segment FSM, two states:
  - START (cnt==0): on accept, latch len = clamp(seg_len). If len==1, stay in START and set last. Otherwise go to RUN with cnt=1.
  - RUN: on accept, cnt++. When cnt == len−1, set last, return to START and set cnt=0.
  - seg_len changes during RUN are ignored.
- Lanes share the counter and the handshake; there is no per-lane stall.
- The accumulator is reset at segment start, so a saturated or zero product does not leak into the next segment.

## Timing
- Latency is 1 cycle: the beat accepted at edge k appears on data_out, valid_out, last_out and sat_out after edge k.
- Throughput is 1 beat/cycle while ready_out=1. The multiply is combinational in the acc feedback loop. If timing requires a pipelined multiplier, that is a new revision; it is not silently allowed.
- Stall (valid_out && !ready_out): all outputs hold stable, ready_in=0, and acc and cnt are frozen.
- Accepting a new beat in the same cycle the held beat drains is legal, giving a back-to-back transfer.
- Reset values, applied at the first edge with rst=1:
  - valid_out=0, data_out=0, last_out=0, sat_out=0.
  - acc=0, cnt=0, state=START.
  - ready_in reads 1 from the cycle after reset.
- Reset mid-segment discards the partial segment. The next accepted beat is a segment start.
- valid_in is ignored while rst=1.

## Structure
- Package cumprod_pkg holds:
  - the CNT_W computation function;
  - the state enum {START, RUN};
  - the saturating fixed-point multiply function mul_sat(a, b, FRAC_W) → {result, ovf}.
- Sub-module cumprod_lane (acc register, mul_sat, sticky flag) is instantiated LANES times by generate.
- The top level owns the FSM, the counter, the output register valid and the handshake.

## Test plan
- Basic scan: DATA_W=16, FRAC_W=8, seg_len=4, lane0 inputs 0x0200, 0x0200, 0x0180, 0x0100 (2, 2, 1.5, 1). Required data_out 0x0200, 0x0400, 0x0600, 0x0600; last_out asserted on beat 4 only; the next segment restarts (input 0x0300 gives 0x0300).
- Saturation: lane1 input 0x7F00 repeated, seg_len=3. Required 0x7F00, 0x7FFF, 0x7FFF; sat_out[1]=0, 1, 1. Sticky clears at the next segment. Negative overflow (0x8000 × 0x0200) gives 0x8000.
- Backpressure: hold ready_out=0 for 5 cycles mid-segment with valid_in=1. Required: ready_in=0, and data_out and last_out stable. After release, the sequence is identical to the no-stall run, with no dropped or duplicated beats.
- Segment-length edges:
  - seg_len=0 and seg_len=1 give last_out on every beat, and data_out equals data_in.
  - seg_len=MAX_SEG+5 behaves as MAX_SEG.
  - Changing seg_len mid-segment has no effect until the next segment start.
- Reset mid-operation: assert rst on beat 2 of a 4-beat segment. Required: valid_out=0 next cycle. The first post-reset beat is a segment start (output equals input), and sat_out=0.
- Lane independence and truncation, with LANES=4:
  - Lanes carry 0x0000, 0xFF00 (−1), 0x0080 (0.5) and random values.
  - Check against a bit-accurate model, including −1 × −1 = 0x0100 and 0x0080 × 0x0001 = 0x0000 (truncation).
  - Check 1000 random beats with random ready_out.

Source files
------------

// File: rtl/cumprod_pkg.sv
// cumprod_pkg: shared types and helpers for the cumprod_stream block.
//   cnt_w    - segment counter width for a given maximum segment length
//   state_t  - segment FSM state (START = next accepted beat opens a segment)
//   mul_sat  - signed fixed-point multiply with truncation and saturation
package cumprod_pkg;

    typedef enum logic {START = 1'b0, RUN = 1'b1} state_t;

    // Result is carried at 32 bits so one function serves any DATA_W <= 32;
    // callers take the low DATA_W bits.
    typedef struct packed {
        logic               ovf;
        logic signed [31:0] res;
    } mul_res_t;

    function automatic int cnt_w(input int max_seg);
        return $clog2(max_seg + 1);
    endfunction

    // p = a*b at full width, q = p >>> frac_w (floor), then clamp to data_w bits.
    function automatic mul_res_t mul_sat(input logic signed [31:0] a,
                                         input logic signed [31:0] b,
                                         input int frac_w,
                                         input int data_w);
        logic signed [63:0] p, q, hi, lo;
        mul_res_t r;
        p  = 64'(a) * 64'(b);
        q  = p >>> frac_w;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (q > hi) begin
            r.res = hi[31:0];
            r.ovf = 1'b1;
        end else if (q < lo) begin
            r.res = lo[31:0];
            r.ovf = 1'b1;
        end else begin
            r.res = q[31:0];
            r.ovf = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/cumprod_stream_if.sv
// cumprod_stream_if: input/output stream of the cumulative-product engine.
//   input side : seg_len, valid_in, ready_in, data_in
//   output side: valid_out, ready_out, data_out, last_out, sat_out
//   slave modport is the engine's view, master is the producer/consumer view.
interface cumprod_stream_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int CNT_W  = 11
);
    logic [CNT_W-1:0]        seg_len;
    logic                    valid_in;
    logic                    ready_in;
    logic [LANES*DATA_W-1:0] data_in;
    logic                    valid_out;
    logic                    ready_out;
    logic [LANES*DATA_W-1:0] data_out;
    logic                    last_out;
    logic [LANES-1:0]        sat_out;

    modport slave (
        input  seg_len, valid_in, data_in, ready_out,
        output ready_in, valid_out, data_out, last_out, sat_out
    );

    modport master (
        output seg_len, valid_in, data_in, ready_out,
        input  ready_in, valid_out, data_out, last_out, sat_out
    );
endinterface

// File: rtl/cumprod_lane.sv
// cumprod_lane: one channel of the running product.
//   clk, rst - clock, synchronous active-high reset
//   accept   - beat is taken this cycle
//   first    - beat opens a segment (product restarts from x)
//   x        - lane input element
//   y        - running product; this register is both the accumulator and
//              the lane's data_out, so a stall freezes both together
//   sat      - sticky saturation flag for the current segment
module cumprod_lane
    import cumprod_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              first,
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic              sat
);
    mul_res_t m;

    always_comb m = mul_sat(32'(signed'(y)), 32'(signed'(x)), FRAC_W, DATA_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            y   <= '0;
            sat <= 1'b0;
        end else if (accept) begin
            if (first) begin
                // unity is never multiplied, so the first element is exact
                y   <= x;
                sat <= 1'b0;
            end else begin
                y   <= m.res[DATA_W-1:0];
                sat <= sat | m.ovf;
            end
        end
    end
endmodule

// File: rtl/cumprod_stream.sv
// cumprod_stream: streaming cumulative product over LANES fixed-point channels,
// restarting every seg_len accepted beats. One-cycle latency, one beat/cycle.
//   clk, rst - clock, synchronous active-high reset
//   bus      - cumprod_stream_if slave (handshake, data, last, sticky sat)
module cumprod_stream
    import cumprod_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int LANES   = 4,
    parameter int MAX_SEG = 1024
) (
    input  logic           clk,
    input  logic           rst,
    cumprod_stream_if.slave bus
);
    localparam int CNT_W = cnt_w(MAX_SEG);

    state_t                        state, state_nxt;
    logic [CNT_W-1:0]              cnt, cnt_nxt, len, len_clamp, len_eff;
    logic                          accept, first, last_nxt, seg_end;
    logic [LANES-1:0][DATA_W-1:0]  lane_y;
    logic [LANES-1:0]              lane_sat;

    // Output register is free when empty or being drained this cycle.
    assign bus.ready_in = !bus.valid_out || bus.ready_out;
    assign accept       = bus.valid_in && bus.ready_in;
    assign first        = (state == START);

    always_comb begin
        if (bus.seg_len == '0)
            len_clamp = CNT_W'(1);
        else if (bus.seg_len > CNT_W'(MAX_SEG))
            len_clamp = CNT_W'(MAX_SEG);
        else
            len_clamp = bus.seg_len;
    end

    // seg_len only matters at a segment start; mid-segment the latched len rules.
    assign len_eff = first ? len_clamp : len;
    assign seg_end = (cnt == len - CNT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= START;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                START:   if (len_eff != CNT_W'(1)) state_nxt = RUN;
                RUN:     if (seg_end)              state_nxt = START;
                default: state_nxt = START;
            endcase
        end
    end

    // Output/counter logic
    always_comb begin
        cnt_nxt  = cnt;
        last_nxt = 1'b0;
        if (accept) begin
            case (state)
                START: begin
                    if (len_eff == CNT_W'(1)) last_nxt = 1'b1;
                    else                      cnt_nxt  = CNT_W'(1);
                end
                RUN: begin
                    if (seg_end) begin
                        last_nxt = 1'b1;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt  = cnt + CNT_W'(1);
                    end
                end
                default: cnt_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            len           <= CNT_W'(1);
            bus.valid_out <= 1'b0;
            bus.last_out  <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (accept && first) len <= len_clamp;
            if (accept) begin
                bus.valid_out <= 1'b1;
                bus.last_out  <= last_nxt;
            end else if (bus.ready_out) begin
                bus.valid_out <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cumprod_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .accept (accept),
            .first  (first),
            .x      (bus.data_in[i*DATA_W +: DATA_W]),
            .y      (lane_y[i]),
            .sat    (lane_sat[i])
        );
    end

    assign bus.data_out = lane_y;
    assign bus.sat_out  = lane_sat;
endmodule

// File: tb/tb_cumprod_stream.sv
module tb_cumprod_stream;
    import cumprod_pkg::*;

    localparam int DATA_W  = 16;
    localparam int FRAC_W  = 8;
    localparam int LANES   = 4;
    localparam int MAX_SEG = 1024;
    localparam int CNT_W   = cnt_w(MAX_SEG);
    localparam int BUS_W   = LANES * DATA_W;

    typedef struct packed {
        logic [BUS_W-1:0] data;
        logic             last;
        logic [LANES-1:0] sat;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cumprod_stream_if #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) bus ();

    cumprod_stream #(
        .DATA_W(DATA_W), .FRAC_W(FRAC_W), .LANES(LANES), .MAX_SEG(MAX_SEG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_chk  = 0;
    int    n_fail = 0;
    beat_t expq[$];
    beat_t obs[$];

    // reference model state
    int     m_cnt = 0;
    int     m_len = 1;
    longint m_acc [LANES];
    bit     m_sat [LANES];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] lane_of(input beat_t b, input int i);
        return b.data[i*DATA_W +: DATA_W];
    endfunction

    // Behavioural model: real-valued product floor-divided by 2^FRAC_W, clamped.
    task automatic model_beat(input logic [BUS_W-1:0] din, input int sl, output beat_t e);
        bit     first;
        longint x, p, q, scale, hi, lo;
        first = (m_cnt == 0);
        scale = longint'(1) << FRAC_W;
        hi    = (longint'(1) << (DATA_W - 1)) - 1;
        lo    = -(longint'(1) << (DATA_W - 1));
        if (first) m_len = (sl < 1) ? 1 : ((sl > MAX_SEG) ? MAX_SEG : sl);
        e = '0;
        for (int i = 0; i < LANES; i++) begin
            x = longint'($signed(din[i*DATA_W +: DATA_W]));
            if (first) begin
                m_acc[i] = x;
                m_sat[i] = 1'b0;
            end else begin
                p = m_acc[i] * x;
                q = p / scale;
                if (p < 0 && (p % scale) != 0) q = q - 1;
                if (q > hi)      begin q = hi; m_sat[i] = 1'b1; end
                else if (q < lo) begin q = lo; m_sat[i] = 1'b1; end
                m_acc[i] = q;
            end
            e.data[i*DATA_W +: DATA_W] = m_acc[i][DATA_W-1:0];
            e.sat[i] = m_sat[i];
        end
        m_cnt++;
        e.last = (m_cnt == m_len);
        if (e.last) m_cnt = 0;
    endtask

    // One bus cycle: drive after the edge, decide acceptance mid-cycle.
    task automatic cycle(input bit v, input logic [BUS_W-1:0] d, input int sl,
                         input bit r, output bit acc);
        beat_t e;
        @(posedge clk); #1;
        bus.valid_in  = v;
        bus.data_in   = d;
        bus.seg_len   = CNT_W'(sl);
        bus.ready_out = r;
        @(negedge clk);
        acc = v && bus.ready_in && !rst;
        if (acc) begin
            model_beat(d, sl, e);
            expq.push_back(e);
        end
    endtask

    task automatic send(input logic [BUS_W-1:0] d, input int sl);
        bit a;
        cycle(1'b1, d, sl, 1'b1, a);
        if (!a) begin
            n_chk++; n_fail++;
            $display("FAIL send_accept: got 0 expected 1");
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1, 1'b1, a);
    endtask

    task automatic do_reset(input logic [BUS_W-1:0] d);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.valid_in  = 1'b1;   // must be ignored during reset
        bus.data_in   = d;
        bus.ready_out = 1'b1;
        @(posedge clk); #1;
        chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
        chk("rst_data_out",  64'(bus.data_out),  64'd0);
        chk("rst_last_out",  64'(bus.last_out),  64'd0);
        chk("rst_sat_out",   64'(bus.sat_out),   64'd0);
        rst = 1'b0;
        bus.valid_in = 1'b0;
        expq.delete();
        m_cnt = 0;
        #1 chk("rst_ready_in", 64'(bus.ready_in), 64'd1);
    endtask

    function automatic logic [BUS_W-1:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                              input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [DATA_W-1:0] rnd_lane();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hFF00;
            2:       return 16'h0080;
            3:       return 16'h0100;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: pop the scoreboard on every output transfer, check stall stability.
    beat_t held;
    bit    stalled = 1'b0;
    always @(negedge clk) begin
        beat_t cur, e;
        cur.data = bus.data_out;
        cur.last = bus.last_out;
        cur.sat  = bus.sat_out;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_data", 64'(cur.data), 64'(held.data));
                chk("stall_last", 64'(cur.last), 64'(held.last));
                chk("stall_sat",  64'(cur.sat),  64'(held.sat));
                if (!bus.ready_out) chk("stall_ready_in", 64'(bus.ready_in), 64'd0);
            end
            if (bus.valid_out && bus.ready_out) begin
                if (expq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_beat: got %h expected none", cur.data);
                end else begin
                    e = expq.pop_front();
                    chk("sb_data", 64'(cur.data), 64'(e.data));
                    chk("sb_last", 64'(cur.last), 64'(e.last));
                    chk("sb_sat",  64'(cur.sat),  64'(e.sat));
                end
                obs.push_back(cur);
            end
            stalled = bus.valid_out && !bus.ready_out;
            held    = cur;
        end
    end

    initial begin
        logic [15:0] exp_d [5];
        logic        exp_l [5];
        logic [BUS_W-1:0] d;
        bit a;
        int got, cyc, nlast, lastidx;

        bus.valid_in  = 1'b0;
        bus.data_in   = '0;
        bus.seg_len   = '0;
        bus.ready_out = 1'b1;
        do_reset('0);

        // basic scan
        obs.delete();
        send(pack4(16'h0200, 16'h0100, 16'h0100, 16'h0100), 4);
        send(pack4(16'h0200, 16'h0100, 16'h0100, 16'h0100), 4);
        send(pack4(16'h0180, 16'h0100, 16'h0100, 16'h0100), 4);
        send(pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100), 4);
        send(pack4(16'h0300, 16'h0100, 16'h0100, 16'h0100), 4);
        idle(2);
        exp_d = '{16'h0200, 16'h0400, 16'h0600, 16'h0600, 16'h0300};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        chk("basic_count", 64'(obs.size()), 64'd5);
        if (obs.size() >= 5)
            for (int i = 0; i < 5; i++) begin
                chk("basic_data", 64'(lane_of(obs[i], 0)), 64'(exp_d[i]));
                chk("basic_last", 64'(obs[i].last), 64'(exp_l[i]));
            end
        do_reset('0);

        // saturation, sticky clear, negative overflow
        obs.delete();
        for (int i = 0; i < 3; i++) send(pack4(16'h0100, 16'h7F00, 16'h0100, 16'h0100), 3);
        send(pack4(16'h0100, 16'h8000, 16'h0100, 16'h0100), 3);
        send(pack4(16'h0100, 16'h0200, 16'h0100, 16'h0100), 3);
        send(pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100), 3);
        idle(2);
        exp_d = '{16'h7F00, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
        exp_l = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};   // sat_out[1] per beat
        chk("sat_count", 64'(obs.size()), 64'd6);
        if (obs.size() >= 5)
            for (int i = 0; i < 5; i++) begin
                chk("sat_data", 64'(lane_of(obs[i], 1)), 64'(exp_d[i]));
                chk("sat_flag", 64'(obs[i].sat[1]), 64'(exp_l[i]));
            end

        // truncation and lane independence
        obs.delete();
        send(pack4(16'h0000, 16'hFF00, 16'h0080, 16'h1234), 2);
        send(pack4(16'h0400, 16'hFF00, 16'h0001, 16'h0200), 2);
        idle(2);
        if (obs.size() >= 2) begin
            chk("trunc_zero",  64'(lane_of(obs[1], 0)), 64'h0000);
            chk("trunc_neg1",  64'(lane_of(obs[1], 1)), 64'h0100);
            chk("trunc_half",  64'(lane_of(obs[1], 2)), 64'h0000);
            chk("trunc_rand",  64'(lane_of(obs[1], 3)), 64'h2468);
        end else chk("trunc_count", 64'(obs.size()), 64'd2);

        // backpressure mid-segment
        send(pack4(16'h0200, 16'h0300, 16'hFF00, 16'h0180), 4);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, pack4(16'h0180, 16'h0080, 16'hFF00, 16'h0200), 4, 1'b0, a);
            chk("bp_no_accept", 64'(a), 64'd0);
        end
        send(pack4(16'h0180, 16'h0080, 16'hFF00, 16'h0200), 4);
        send(pack4(16'h0100, 16'h0400, 16'h0300, 16'h0080), 4);
        send(pack4(16'h0200, 16'h0100, 16'hFF00, 16'h0200), 4);
        idle(2);

        // seg_len 0 and 1: every beat closes a segment and passes through
        obs.delete();
        for (int i = 0; i < 6; i++) send(pack4(16'($urandom), 16'($urandom), 16'h0200, 16'h7F00), i % 2);
        idle(2);
        chk("len01_count", 64'(obs.size()), 64'd6);
        foreach (obs[i]) chk("len01_last", 64'(obs[i].last), 64'd1);

        // seg_len change mid-segment is ignored
        send(pack4(16'h0200, 16'h0100, 16'h0100, 16'h0100), 3);
        send(pack4(16'h0200, 16'h0100, 16'h0100, 16'h0100), 1);
        send(pack4(16'h0200, 16'h0100, 16'h0100, 16'h0100), 0);
        send(pack4(16'h0200, 16'h0100, 16'h0100, 16'h0100), 2);
        send(pack4(16'h0200, 16'h0100, 16'h0100, 16'h0100), 7);
        idle(2);

        // seg_len above MAX_SEG clamps to MAX_SEG
        obs.delete();
        for (int i = 0; i < MAX_SEG + 1; i++) send(pack4(16'h0100, 16'h0100, 16'h0080, 16'hFF00), MAX_SEG + 5);
        idle(2);
        nlast = 0; lastidx = -1;
        foreach (obs[i]) if (obs[i].last) begin nlast++; lastidx = i; end
        chk("maxseg_nlast", 64'(nlast), 64'd1);
        chk("maxseg_idx", 64'(lastidx), 64'(MAX_SEG - 1));

        // reset in the middle of a 4-beat segment (saturated lane first)
        send(pack4(16'h7F00, 16'h0200, 16'h0100, 16'h0100), 4);
        send(pack4(16'h7F00, 16'h0200, 16'h0100, 16'h0100), 4);
        do_reset(pack4(16'h7F00, 16'h0200, 16'h0100, 16'h0100));
        obs.delete();
        send(pack4(16'h0345, 16'h0200, 16'h0100, 16'hFF00), 4);
        idle(2);
        if (obs.size() >= 1) begin
            chk("post_rst_data", 64'(obs[0].data), 64'(pack4(16'h0345, 16'h0200, 16'h0100, 16'hFF00)));
            chk("post_rst_sat", 64'(obs[0].sat), 64'd0);
        end else chk("post_rst_count", 64'(obs.size()), 64'd1);
        do_reset('0);

        // random traffic with random backpressure
        got = 0; cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            d = pack4(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
            cycle(($urandom_range(0, 3) != 0), d, $urandom_range(0, 6),
                  ($urandom_range(0, 2) != 0), a);
            if (a) got++;
            cyc++;
        end
        chk("rand_beats", 64'(got), 64'd1000);

        // drain
        cyc = 0;
        while (expq.size() != 0 && cyc < 20) begin idle(1); cyc++; end
        chk("drain_empty", 64'(expq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
